id_stage: RTL and testbench



---
 rtl/id_stage_if.sv | 71 +++++++
 rtl/id_stage.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Handshake/bus bundles for the RV32I decode stage.
//
// Macro: ID_ILLEGAL_TRAP_EN adds out_illegal to id_out_if.
//
// id_in_if  : fetch -> decode.
//   in_valid  fetch presents an instruction
//   in_ready  decode accepts this cycle
//   in_instr  32-bit instruction word
//   in_pc     32-bit instruction address
//   modports: master = fetch side, slave = decode side
//
// id_out_if : decode -> execute (ALU control/operand bundle).
//   out_valid, out_ready       handshake
//   out_alu_ctrl, out_cmp_ctrl ALU / comparator opcodes
//   out_a, out_b, out_imm      operands and sign-extended immediate
//   out_pc, out_rd, out_rd_we  PC, destination register, write enable
//   out_res_sel                0=ALU, 1=cmp result, 2=PC+4
//   out_is_branch, out_is_jump control-flow flags
//   out_illegal                only with ID_ILLEGAL_TRAP_EN
//   modports: master = decode side, slave = execute side

interface id_in_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  modport master (output in_valid, output in_instr, output in_pc, input in_ready);
  modport slave  (input in_valid, input in_instr, input in_pc, output in_ready);
endinterface

interface id_out_if;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctrl;
  logic [2:0]  out_cmp_ctrl;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] out_imm;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [1:0]  out_res_sel;
  logic        out_is_branch;
  logic        out_is_jump;
`ifdef ID_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  modport master (
    output out_valid, input out_ready,
    output out_alu_ctrl, output out_cmp_ctrl,
    output out_a, output out_b, output out_imm, output out_pc,
    output out_rd, output out_rd_we, output out_res_sel,
`ifdef ID_ILLEGAL_TRAP_EN
    output out_illegal,
`endif
    output out_is_branch, output out_is_jump
  );

  modport slave (
    input out_valid, output out_ready,
    input out_alu_ctrl, input out_cmp_ctrl,
    input out_a, input out_b, input out_imm, input out_pc,
    input out_rd, input out_rd_we, input out_res_sel,
`ifdef ID_ILLEGAL_TRAP_EN
    input out_illegal,
`endif
    input out_is_branch, input out_is_jump
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: registered RV32I instruction decode producing the ALU bundle.
//
// Macro: ID_ILLEGAL_TRAP_EN -- when defined, exec.out_illegal is driven and
// registered with the bundle; otherwise illegal encodings leave as NOP bubbles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fetch (id_in_if)    instruction in, valid/ready handshake
//   rs1_addr, rs2_addr  register-file read addresses (combinational)
//   rs1_data, rs2_data  same-cycle register-file read data
//   flush               drops held and incoming instruction
//   exec (id_out_if)    decoded bundle out, valid/ready handshake

module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  id_in_if.slave      fetch,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  id_out_if.master    exec
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR  = 4'd3,
    ALU_AND = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_NOP = 4'd8
  } alu_op_e;

  typedef enum logic [2:0] {
    CMP_EQ = 3'd0, CMP_NE = 3'd1, CMP_LT = 3'd2,
    CMP_GE = 3'd3, CMP_LTU = 3'd4, CMP_GEU = 3'd5
  } cmp_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0, RES_CMP = 2'd1, RES_PC4 = 2'd2
  } res_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // funct3 -> ALU op for OP / OP-IMM. SLT/SLTU (010/011) go to the
  // comparator, so the ALU idles on NOP for them.
  function automatic alu_op_e alu_of_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic cmp_op_e cmp_of_branch(input logic [2:0] f3);
    case (f3)
      3'b001:  return CMP_NE;
      3'b100:  return CMP_LT;
      3'b101:  return CMP_GE;
      3'b110:  return CMP_LTU;
      3'b111:  return CMP_GEU;
      default: return CMP_EQ;
    endcase
  endfunction

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd_f;
  logic        is_slt;

  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;
  logic signed [31:0] pc_s;
  logic signed [31:0] imm_i;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_j;
  logic signed [31:0] shamt;

  assign instr  = fetch.in_instr;
  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign is_slt = (f3[2:1] == 2'b01);

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  assign rs1_s = $signed(rs1_data);
  assign rs2_s = $signed(rs2_data);
  assign pc_s  = $signed(fetch.in_pc);
  assign imm_i = $signed({{20{instr[31]}}, instr[31:20]});
  assign imm_u = $signed({instr[31:12], 12'b0});
  assign imm_b = $signed({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
  assign imm_j = $signed({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
  assign shamt = $signed({27'b0, instr[24:20]});

  // ---- stage p0: combinational decode of the incoming instruction ----
  alu_op_e            alu_ctrl_p0;
  cmp_op_e            cmp_ctrl_p0;
  res_sel_e           res_sel_p0;
  logic signed [31:0] a_p0;
  logic signed [31:0] b_p0;
  logic signed [31:0] imm_p0;
  logic [4:0]         rd_p0;
  logic               rd_we_p0;
  logic               wr_p0;
  logic               br_p0;
  logic               jmp_p0;
  logic               ill_p0;

  always_comb begin
    alu_ctrl_p0 = ALU_NOP;
    cmp_ctrl_p0 = CMP_EQ;
    res_sel_p0  = RES_ALU;
    a_p0        = '0;
    b_p0        = '0;
    imm_p0      = '0;
    wr_p0       = 1'b0;
    br_p0       = 1'b0;
    jmp_p0      = 1'b0;
    ill_p0      = 1'b1;

    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
          ill_p0      = 1'b0;
          wr_p0       = 1'b1;
          a_p0        = rs1_s;
          b_p0        = rs2_s;
          alu_ctrl_p0 = alu_of_f3(f3, f7 == F7_ALT);
          if (is_slt) begin
            res_sel_p0  = RES_CMP;
            cmp_ctrl_p0 = f3[0] ? CMP_LTU : CMP_LT;
          end
        end
      end
      OPC_OPIMM: begin
        // Only the shift forms constrain funct7; the rest carry immediate bits there.
        if ((f3 == 3'b001 && f7 == F7_BASE) ||
            (f3 == 3'b101 && (f7 == F7_BASE || f7 == F7_ALT)) ||
            (f3 != 3'b001 && f3 != 3'b101)) begin
          ill_p0      = 1'b0;
          wr_p0       = 1'b1;
          a_p0        = rs1_s;
          imm_p0      = imm_i;
          b_p0        = (f3[1:0] == 2'b01) ? shamt : imm_i;
          alu_ctrl_p0 = alu_of_f3(f3, f3 == 3'b101 && f7 == F7_ALT);
          if (is_slt) begin
            res_sel_p0  = RES_CMP;
            cmp_ctrl_p0 = f3[0] ? CMP_LTU : CMP_LT;
          end
        end
      end
      OPC_LUI: begin
        ill_p0      = 1'b0;
        wr_p0       = 1'b1;
        alu_ctrl_p0 = ALU_ADD;
        b_p0        = imm_u;
        imm_p0      = imm_u;
      end
      OPC_AUIPC: begin
        ill_p0      = 1'b0;
        wr_p0       = 1'b1;
        alu_ctrl_p0 = ALU_ADD;
        a_p0        = pc_s;
        b_p0        = imm_u;
        imm_p0      = imm_u;
      end
      OPC_JAL: begin
        ill_p0      = 1'b0;
        wr_p0       = 1'b1;
        jmp_p0      = 1'b1;
        alu_ctrl_p0 = ALU_ADD;
        res_sel_p0  = RES_PC4;
        a_p0        = pc_s;
        b_p0        = imm_j;
        imm_p0      = imm_j;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          ill_p0      = 1'b0;
          wr_p0       = 1'b1;
          jmp_p0      = 1'b1;
          alu_ctrl_p0 = ALU_ADD;
          res_sel_p0  = RES_PC4;
          a_p0        = rs1_s;
          b_p0        = imm_i;
          imm_p0      = imm_i;
        end
      end
      OPC_BRANCH: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          ill_p0      = 1'b0;
          br_p0       = 1'b1;
          cmp_ctrl_p0 = cmp_of_branch(f3);
          a_p0        = rs1_s;
          b_p0        = rs2_s;
          imm_p0      = imm_b;
        end
      end
      default: ;
    endcase

    rd_p0    = wr_p0 ? rd_f : 5'd0;
    rd_we_p0 = wr_p0 && (rd_f != 5'd0);
  end

  // ---- stage p1: output register and handshake ----
  logic               vld_p1;
  logic               in_ready;
  logic               take;
  alu_op_e            alu_ctrl_p1;
  cmp_op_e            cmp_ctrl_p1;
  res_sel_e           res_sel_p1;
  logic signed [31:0] a_p1;
  logic signed [31:0] b_p1;
  logic signed [31:0] imm_p1;
  logic [31:0]        pc_p1;
  logic [4:0]         rd_p1;
  logic               rd_we_p1;
  logic               br_p1;
  logic               jmp_p1;

  assign in_ready = !vld_p1 || exec.out_ready;
  assign take     = fetch.in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (take) begin
      vld_p1 <= 1'b1;
    end else if (exec.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // The bundle is architecturally visible after reset, so it is cleared too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl_p1 <= ALU_NOP;
      cmp_ctrl_p1 <= CMP_EQ;
      res_sel_p1  <= RES_ALU;
      a_p1        <= '0;
      b_p1        <= '0;
      imm_p1      <= '0;
      pc_p1       <= '0;
      rd_p1       <= '0;
      rd_we_p1    <= 1'b0;
      br_p1       <= 1'b0;
      jmp_p1      <= 1'b0;
    end else if (take) begin
      alu_ctrl_p1 <= alu_ctrl_p0;
      cmp_ctrl_p1 <= cmp_ctrl_p0;
      res_sel_p1  <= res_sel_p0;
      a_p1        <= a_p0;
      b_p1        <= b_p0;
      imm_p1      <= imm_p0;
      pc_p1       <= fetch.in_pc;
      rd_p1       <= rd_p0;
      rd_we_p1    <= rd_we_p0;
      br_p1       <= br_p0;
      jmp_p1      <= jmp_p0;
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  logic ill_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_p1 <= 1'b0;
    end else if (take) begin
      ill_p1 <= ill_p0;
    end
  end

  assign exec.out_illegal = ill_p1;
`else
  // Without the trap port an illegal word simply leaves as a NOP bubble.
  logic unused_ill;
  assign unused_ill = ill_p0;
`endif

  assign fetch.in_ready     = in_ready;
  assign exec.out_valid     = vld_p1;
  assign exec.out_alu_ctrl  = alu_ctrl_p1;
  assign exec.out_cmp_ctrl  = cmp_ctrl_p1;
  assign exec.out_res_sel   = res_sel_p1;
  assign exec.out_a         = a_p1;
  assign exec.out_b         = b_p1;
  assign exec.out_imm       = imm_p1;
  assign exec.out_pc        = pc_p1;
  assign exec.out_rd        = rd_p1;
  assign exec.out_rd_we     = rd_we_p1;
  assign exec.out_is_branch = br_p1;
  assign exec.out_is_jump   = jmp_p1;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed cases plus random instructions and
// handshake traffic, checked against an instruction-level reference model.

module tb_id_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  id_in_if  fi ();
  id_out_if fo ();

  id_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch    (fi.slave),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .flush    (flush),
    .exec     (fo.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {
    M_ILL,
    M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND,
    M_ADDI, M_SLLI, M_SLTI, M_SLTIU, M_XORI, M_SRLI, M_SRAI, M_ORI, M_ANDI,
    M_LUI, M_AUIPC, M_JAL, M_JALR,
    M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU
  } mnem_e;

  typedef struct packed {
    logic [3:0]  alu;
    logic [2:0]  cmp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  rsel;
    logic        br;
    logic        jp;
    logic        ill;
  } bundle_t;

  mnem_e op_tab  [8] = '{M_ADD, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_OR, M_AND};
  mnem_e opi_tab [8] = '{M_ADDI, M_ILL, M_SLTI, M_SLTIU, M_XORI, M_ILL, M_ORI, M_ANDI};
  mnem_e br_tab  [8] = '{M_BEQ, M_BNE, M_ILL, M_ILL, M_BLT, M_BGE, M_BLTU, M_BGEU};

  function automatic mnem_e classify(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    case (opc)
      7'h33: begin
        if (f7 == 7'h00) return op_tab[f3];
        if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
        if (f7 == 7'h20 && f3 == 3'd5) return M_SRA;
        return M_ILL;
      end
      7'h13: begin
        if (f3 == 3'd1) return (f7 == 7'h00) ? M_SLLI : M_ILL;
        if (f3 == 3'd5) return (f7 == 7'h00) ? M_SRLI : ((f7 == 7'h20) ? M_SRAI : M_ILL);
        return opi_tab[f3];
      end
      7'h37: return M_LUI;
      7'h17: return M_AUIPC;
      7'h6F: return M_JAL;
      7'h67: return (f3 == 3'd0) ? M_JALR : M_ILL;
      7'h63: return br_tab[f3];
      default: return M_ILL;
    endcase
  endfunction

  function automatic bundle_t ref_bundle(input logic [31:0] w, input logic [31:0] p,
                                         input logic [31:0] r1, input logic [31:0] r2);
    bundle_t     e;
    mnem_e       m;
    logic [31:0] iimm, uimm, bimm, jimm;
    logic        writes;
    m      = classify(w);
    iimm   = 32'($signed(w[31:20]));
    uimm   = w & 32'hFFFF_F000;
    bimm   = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    jimm   = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    e      = '0;
    e.pc   = p;
    e.ill  = (m == M_ILL);
    writes = 1'b0;

    case (m)
      M_ADD, M_ADDI, M_LUI, M_AUIPC, M_JAL, M_JALR: e.alu = 4'd0;
      M_SUB:         e.alu = 4'd1;
      M_XOR, M_XORI: e.alu = 4'd2;
      M_OR,  M_ORI:  e.alu = 4'd3;
      M_AND, M_ANDI: e.alu = 4'd4;
      M_SLL, M_SLLI: e.alu = 4'd5;
      M_SRL, M_SRLI: e.alu = 4'd6;
      M_SRA, M_SRAI: e.alu = 4'd7;
      default:       e.alu = 4'd8;
    endcase

    case (m)
      M_BNE:                e.cmp = 3'd1;
      M_SLT, M_SLTI, M_BLT: e.cmp = 3'd2;
      M_BGE:                e.cmp = 3'd3;
      M_SLTU, M_SLTIU, M_BLTU: e.cmp = 3'd4;
      M_BGEU:               e.cmp = 3'd5;
      default:              e.cmp = 3'd0;
    endcase

    case (m)
      M_SLT, M_SLTU, M_SLTI, M_SLTIU: e.rsel = 2'd1;
      M_JAL, M_JALR:                  e.rsel = 2'd2;
      default:                        e.rsel = 2'd0;
    endcase

    case (m)
      M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND: begin
        e.a = r1; e.b = r2; writes = 1'b1;
      end
      M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_JALR: begin
        e.a = r1; e.b = iimm; e.imm = iimm; writes = 1'b1;
      end
      M_SLLI, M_SRLI, M_SRAI: begin
        e.a = r1; e.b = 32'(w[24:20]); e.imm = iimm; writes = 1'b1;
      end
      M_LUI:   begin e.b = uimm; e.imm = uimm; writes = 1'b1; end
      M_AUIPC: begin e.a = p; e.b = uimm; e.imm = uimm; writes = 1'b1; end
      M_JAL:   begin e.a = p; e.b = jimm; e.imm = jimm; writes = 1'b1; end
      M_BEQ, M_BNE, M_BLT, M_BGE, M_BLTU, M_BGEU: begin
        e.a = r1; e.b = r2; e.imm = bimm; e.br = 1'b1;
      end
      default: ;
    endcase

    e.jp = (m == M_JAL) || (m == M_JALR);
    if (writes) begin
      e.rd = w[11:7];
      e.we = (w[11:7] != 5'd0);
    end
    return e;
  endfunction

  bundle_t     q[$];
  logic [31:0] regs [32];

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  f7pick;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    case ($urandom_range(0, 2))
      0:       f7pick = 7'h00;
      1:       f7pick = 7'h20;
      default: f7pick = 7'($urandom);
    endcase
    case (sel)
      0, 1: begin w[6:0] = 7'h33; w[31:25] = f7pick; end
      2, 3: begin w[6:0] = 7'h13; if (w[13:12] == 2'b01) w[31:25] = f7pick; end
      4:    w[6:0] = 7'h37;
      5:    w[6:0] = 7'h17;
      6:    w[6:0] = 7'h6F;
      7:    begin w[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0; end
      8:    w[6:0] = 7'h63;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic compare_out();
    bundle_t e;
    chk("out_valid", fo.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      e = q[0];
      chk("alu_ctrl", fo.out_alu_ctrl, e.alu);
      chk("cmp_ctrl", fo.out_cmp_ctrl, e.cmp);
      chk("a", fo.out_a, e.a);
      chk("b", fo.out_b, e.b);
      chk("imm", fo.out_imm, e.imm);
      chk("pc", fo.out_pc, e.pc);
      chk("rd", fo.out_rd, e.rd);
      chk("rd_we", fo.out_rd_we, e.we);
      chk("res_sel", fo.out_res_sel, e.rsel);
      chk("is_branch", fo.out_is_branch, e.br);
      chk("is_jump", fo.out_is_jump, e.jp);
`ifdef ID_ILLEGAL_TRAP_EN
      chk("illegal", fo.out_illegal, e.ill);
`endif
    end
  endtask

  // One cycle: drive at the negedge, check handshake/addresses, advance the
  // model for the coming posedge, then check outputs at the following negedge.
  task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p,
                      input logic ordy, input logic fl);
    logic exp_rdy;
    fi.in_valid  = v;
    fi.in_instr  = w;
    fi.in_pc     = p;
    fo.out_ready = ordy;
    flush        = fl;
    rs1_data     = regs[w[19:15]];
    rs2_data     = regs[w[24:20]];
    #1;
    exp_rdy = (q.size() == 0) || ordy;
    chk("in_ready", fi.in_ready, exp_rdy);
    chk("rs1_addr", rs1_addr, w[19:15]);
    chk("rs2_addr", rs2_addr, w[24:20]);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (v && exp_rdy) q.push_back(ref_bundle(w, p, rs1_data, rs2_data));
    end
    @(negedge clk);
    compare_out();
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b1;
    flush        = 1'b0;
    fi.in_valid  = 1'b0;
    fi.in_instr  = '0;
    fi.in_pc     = '0;
    fo.out_ready = 1'b0;
    rs1_data     = '0;
    rs2_data     = '0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0;
    regs[1] = 32'd10;
    regs[2] = 32'd3;

    #1 rst_n = 1'b0;
    #2;
    chk("rst out_valid", fo.out_valid, 1'b0);
    chk("rst alu_ctrl", fo.out_alu_ctrl, 4'd8);
    chk("rst a", fo.out_a, 32'd0);
    chk("rst pc", fo.out_pc, 32'd0);
    chk("rst rd_we", fo.out_rd_we, 1'b0);
    chk("rst in_ready", fi.in_ready, 1'b1);
`ifdef ID_ILLEGAL_TRAP_EN
    chk("rst illegal", fo.out_illegal, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x0,5
    step(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    chk("addi valid", fo.out_valid, 1'b1);
    chk("addi alu", fo.out_alu_ctrl, 4'd0);
    chk("addi a", fo.out_a, 32'd0);
    chk("addi b", fo.out_b, 32'd5);
    chk("addi rd", fo.out_rd, 5'd1);
    chk("addi we", fo.out_rd_we, 1'b1);
    chk("addi rsel", fo.out_res_sel, 2'd0);

    // sub x3,x1,x2
    step(1'b1, 32'h4020_81B3, 32'h104, 1'b1, 1'b0);
    chk("sub alu", fo.out_alu_ctrl, 4'd1);
    chk("sub a", fo.out_a, 32'd10);
    chk("sub b", fo.out_b, 32'd3);
    chk("sub rd", fo.out_rd, 5'd3);

    // bne x1,x2,8
    step(1'b1, 32'h0020_9463, 32'h108, 1'b1, 1'b0);
    chk("bne cmp", fo.out_cmp_ctrl, 3'd1);
    chk("bne alu", fo.out_alu_ctrl, 4'd8);
    chk("bne br", fo.out_is_branch, 1'b1);
    chk("bne imm", fo.out_imm, 32'd8);
    chk("bne we", fo.out_rd_we, 1'b0);

    // srai x5,x6,3
    step(1'b1, 32'h4033_5293, 32'h10C, 1'b1, 1'b0);
    chk("srai alu", fo.out_alu_ctrl, 4'd7);
    chk("srai b", fo.out_b, 32'd3);
    chk("srai rd", fo.out_rd, 5'd5);

    // all-ones word is illegal
    step(1'b1, 32'hFFFF_FFFF, 32'h110, 1'b1, 1'b0);
    chk("ill valid", fo.out_valid, 1'b1);
    chk("ill alu", fo.out_alu_ctrl, 4'd8);
    chk("ill we", fo.out_rd_we, 1'b0);
`ifdef ID_ILLEGAL_TRAP_EN
    chk("ill flag", fo.out_illegal, 1'b1);
`endif

    // backpressure: hold addi for 3 cycles while sub waits, then flush
    step(1'b1, 32'h0050_0093, 32'h114, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h4020_81B3, 32'h118, 1'b0, 1'b0);
      chk("stall in_ready", fi.in_ready, 1'b0);
      chk("stall pc", fo.out_pc, 32'h114);
      chk("stall b", fo.out_b, 32'd5);
      chk("stall valid", fo.out_valid, 1'b1);
    end
    step(1'b1, 32'h4020_81B3, 32'h118, 1'b0, 1'b1);
    chk("flush valid", fo.out_valid, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("post-flush valid", fo.out_valid, 1'b0);

    // async reset in the middle of a stall
    step(1'b1, 32'h0050_0093, 32'h200, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst valid", fo.out_valid, 1'b0);
    chk("midrst alu", fo.out_alu_ctrl, 4'd8);
    chk("midrst pc", fo.out_pc, 32'd0);
    chk("midrst b", fo.out_b, 32'd0);
    chk("midrst in_ready", fi.in_ready, 1'b1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, gen_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    // drain
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
